icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Instruction-cache controller between the instruction buffer and the instruction-memory port.
- Each cycle it answers the buffer's fetch request (base PC plus count) from an internal direct-mapped line store, returning up to N_WAY consecutive instructions as a contiguous valid prefix.
- On a miss it sequences one outstanding line fill over the tagged memory bus (command/response/tag).
- Hits are served while a fill is outstanding (hit-under-miss).

Parameters:
- ICACHE_LINES, 32, number of direct-mapped lines; power of two.
- LINE_BYTES, 8, bytes per line (two 32-bit instructions); fixed to the 64-bit memory bus width.
- N_WAY, `N_WAY, fetch width; taken from the global define.
- XLEN, `XLEN, address width; taken from the global define.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock (clock); sampled only on posedge clock.
- enable  in  1  when 0: outputs forced invalid, FSM holds, no new requests.
- branch_taken  in  1  redirect seen by the buffer; clears the pending miss address.
- buff2Icache_addr  in  XLEN  fetch base PC, word aligned.
- buff2Icache_count  in  clog2(N_WAY)+1  number of instructions wanted, 0..N_WAY.
- Icache2buff_addr  out  N_WAY x XLEN  slot i = base + 4*i.
- Icache2buff_data  out  N_WAY x XLEN  instruction words.
- Icache2buff_valid  out  N_WAY  contiguous valid prefix.
- Icache2buff_hit_count  out  clog2(N_WAY)+1  number of valid slots.
- proc2Imem_command  out  2  BUS_NONE / BUS_LOAD.
- proc2Imem_addr  out  XLEN  line-aligned fill address.
- Imem2proc_response  in  4  nonzero = request accepted, carries its tag.
- Imem2proc_data  in  64  fill data.
- Imem2proc_tag  in  4  tag of the returning data; 0 = none.

Behaviour:
- Address split: offset [2:0]; index [2+log2(ICACHE_LINES):3]; tag = the remaining upper bits.
  - With defaults: index [7:3], tag [31:8].
  - Word select: addr[2].
- Storage per line: valid bit, tag, 64-bit data.
- Lookup (combinational, 0-cycle latency). For slot i:
  - hit_i = line valid && tag match for (base + 4i).
  - Icache2buff_valid[i] = enable && i < count && hit_0 .. hit_i all true.
  - Slots after the first miss are always 0; there are never trailing ones.
  - hit_count = popcount(valid).
  - addr and data are driven for every slot regardless of valid.
- miss_addr: line-aligned address of the first slot i < count that misses. A miss exists only if enable = 1.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: a miss exists and branch_taken = 0 → latch miss_addr into req_addr, go to REQ.
  - REQ:
    - Drive proc2Imem_command = BUS_LOAD and proc2Imem_addr = req_addr.
    - Response != 0 → save it as pend_tag, go to WAIT.
    - Response == 0 → stay in REQ and retry; command stays asserted.
    - enable = 0 in REQ → command still held; the request is not dropped.
  - WAIT:
    - Imem2proc_tag == pend_tag and tag != 0 → write the line (valid = 1, tag, data); go to IDLE.
    - The fill write happens regardless of enable and branch_taken.
    - The written line is visible to lookup the next cycle.
- Command is BUS_NONE in IDLE and WAIT.
- branch_taken:
  - In IDLE: suppresses the miss latch that cycle.
  - In REQ or WAIT: the fill completes normally. The data is still correct, so no discard is needed.
- Only one fill is outstanding at a time. A new miss during WAIT waits for IDLE.
- Eviction: a fill overwrites the indexed line unconditionally.
- Same-cycle fill and lookup of the same line: lookup sees the old contents.
- count = 0 or enable = 0: valid = 0, hit_count = 0, no miss.
- Reset:
  - All line valid bits cleared; FSM to IDLE; pend_tag and req_addr set to 0.
  - proc2Imem_command = BUS_NONE, proc2Imem_addr = 0.
  - Icache2buff_valid = 0, hit_count = 0.
  - Reset during REQ or WAIT abandons the fill; a later matching tag is ignored.

Decomposition:
- Shared package / defines file holds:
  - BUS_NONE / BUS_LOAD command encoding.
  - ICACHE_LINES and the derived index/tag widths.
  - The icache_state_t enum {IDLE, REQ, WAIT}.
  - ICACHE_LINE_T struct {valid, tag, data}.
- One sub-module, icache_mem: the line array.
  - Reads: N_WAY combinational read ports.
  - Write: one synchronous port with a valid-clear on reset.
- The controller holds the FSM and the lookup/prefix logic.

Test Plan:
- Reset, then count = 3 at 0x0 → valid = 000, hit_count = 0. Next cycle: command = BUS_LOAD, addr = 0x0.
- Cold miss fill:
  - Response = 5 in the first REQ cycle; two cycles later tag = 5 with data 0x00000013_00100093.
  - The cycle after the tag: valid = 011, hit_count = 2, data[0] = 0x00100093, data[1] = 0x00000013.
  - Next request: addr = 0x8.
- Retry: response = 0 for 3 cycles, then 7 → command held BUS_LOAD at the same address for 4 cycles, then BUS_NONE. Fill on tag 7.
- Hit under miss: line 0x0 resident, WAIT on 0x8; request base 0x0, count = 2 → valid = 011 while command = BUS_NONE. Tag 3 arrives for a non-pending tag → no write.
- Conflict: fill 0x100 (index 0) after 0x0 is resident → subsequent base 0x0 gives valid = 000 and re-requests 0x0.
- Redirect: branch_taken asserted in WAIT → fill still written. Branch_taken in IDLE with a miss → no REQ that cycle; REQ the next cycle. Reset during WAIT, then matching tag → line stays invalid.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and parameters for the instruction-cache controller slice.
// Bus command encoding, line-store geometry, FSM state and line record.
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef XLEN
`define XLEN 32
`endif

package icache_pkg;
  localparam int XLEN         = `XLEN;
  localparam int N_WAY        = `N_WAY;
  localparam int ICACHE_LINES = 32;
  localparam int LINE_BYTES   = 8;
  localparam int IDX_W        = $clog2(ICACHE_LINES);
  localparam int TAG_W        = XLEN - $clog2(LINE_BYTES) - IDX_W;
  localparam int CNT_W        = $clog2(N_WAY) + 1;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } icache_state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } ICACHE_LINE_T;

  function automatic logic [IDX_W-1:0] addr_index(input logic [XLEN-1:0] addr);
    return addr[2+IDX_W:3];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [XLEN-1:0] addr);
    return addr[XLEN-1:3+IDX_W];
  endfunction
endpackage

// File: rtl/icache_mem.sv
// Direct-mapped line array: N_WAY combinational read ports, one synchronous
// write port; reset clears only the valid bits.
module icache_mem
  import icache_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_WAY-1:0][IDX_W-1:0]     rd_idx,
  output ICACHE_LINE_T [N_WAY-1:0]        rd_line,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_idx,
  input  logic [TAG_W-1:0]                wr_tag,
  input  logic [63:0]                     wr_data
);
  ICACHE_LINE_T lines [ICACHE_LINES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ICACHE_LINES; i++) lines[i].valid <= 1'b0;
    end else if (wr_en) begin
      lines[wr_idx] <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
    end
  end

  always_comb begin
    for (int i = 0; i < N_WAY; i++) rd_line[i] = lines[rd_idx[i]];
  end
endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: zero-latency prefix lookup for the fetch
// buffer plus a single-outstanding line-fill sequencer on the tagged bus.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            branch_taken,
  input  logic [XLEN-1:0]                 buff2Icache_addr,
  input  logic [CNT_W-1:0]                buff2Icache_count,
  output logic [N_WAY-1:0][XLEN-1:0]      Icache2buff_addr,
  output logic [N_WAY-1:0][XLEN-1:0]      Icache2buff_data,
  output logic [N_WAY-1:0]                Icache2buff_valid,
  output logic [CNT_W-1:0]                Icache2buff_hit_count,
  output logic [1:0]                      proc2Imem_command,
  output logic [XLEN-1:0]                 proc2Imem_addr,
  input  logic [3:0]                      Imem2proc_response,
  input  logic [63:0]                     Imem2proc_data,
  input  logic [3:0]                      Imem2proc_tag
);
  icache_state_t              state;
  logic [XLEN-1:0]            req_addr;
  logic [3:0]                 pend_tag;
  logic [N_WAY-1:0][IDX_W-1:0] rd_idx;
  ICACHE_LINE_T [N_WAY-1:0]   rd_line;
  logic [N_WAY-1:0]           hit;
  logic                       miss_found;
  logic [XLEN-1:0]            miss_addr;
  logic                       fill_done;
  logic                       run;

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      Icache2buff_addr[i] = buff2Icache_addr + XLEN'(4 * i);
      rd_idx[i]           = addr_index(Icache2buff_addr[i]);
    end
  end

  icache_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .rd_idx  (rd_idx),
    .rd_line (rd_line),
    .wr_en   (fill_done),
    .wr_idx  (addr_index(req_addr)),
    .wr_tag  (addr_tag(req_addr)),
    .wr_data (Imem2proc_data)
  );

  // The valid prefix stops at the first miss; that slot's line is the fill target.
  always_comb begin
    run                   = enable && !reset;
    miss_found            = 1'b0;
    miss_addr             = '0;
    Icache2buff_valid     = '0;
    Icache2buff_hit_count = '0;
    for (int i = 0; i < N_WAY; i++) begin
      hit[i] = rd_line[i].valid && (rd_line[i].tag == addr_tag(Icache2buff_addr[i]));
      Icache2buff_data[i] = Icache2buff_addr[i][2] ? rd_line[i].data[63:32]
                                                   : rd_line[i].data[31:0];
      if (run && (CNT_W'(i) < buff2Icache_count)) begin
        if (hit[i]) begin
          Icache2buff_valid[i]  = 1'b1;
          Icache2buff_hit_count = Icache2buff_hit_count + CNT_W'(1);
        end else begin
          run        = 1'b0;
          miss_found = 1'b1;
          miss_addr  = {Icache2buff_addr[i][XLEN-1:3], 3'b000};
        end
      end else begin
        run = 1'b0;
      end
    end
  end

  assign fill_done      = (state == WAIT) && (Imem2proc_tag != 4'd0) && (Imem2proc_tag == pend_tag);
  assign proc2Imem_addr = req_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      req_addr          <= '0;
      pend_tag          <= '0;
      proc2Imem_command <= BUS_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (miss_found && !branch_taken) begin
            req_addr          <= miss_addr;
            proc2Imem_command <= BUS_LOAD;
            state             <= REQ;
          end
        end
        REQ: begin
          // Once the command is on the bus an acceptance is honoured even if enable drops.
          if (Imem2proc_response != 4'd0) begin
            pend_tag          <= Imem2proc_response;
            proc2Imem_command <= BUS_NONE;
            state             <= WAIT;
          end
        end
        WAIT: begin
          if (fill_done) state <= IDLE;
        end
        default: begin
          proc2Imem_command <= BUS_NONE;
          state             <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl: lookup vector table plus
// hand-written fill, retry, hit-under-miss, conflict, redirect and reset sequences.
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_icache_ctrl;
  import icache_pkg::*;

  logic                       clock;
  logic                       reset;
  logic                       enable;
  logic                       branch_taken;
  logic [XLEN-1:0]            buff2Icache_addr;
  logic [CNT_W-1:0]           buff2Icache_count;
  logic [N_WAY-1:0][XLEN-1:0] Icache2buff_addr;
  logic [N_WAY-1:0][XLEN-1:0] Icache2buff_data;
  logic [N_WAY-1:0]           Icache2buff_valid;
  logic [CNT_W-1:0]           Icache2buff_hit_count;
  logic [1:0]                 proc2Imem_command;
  logic [XLEN-1:0]            proc2Imem_addr;
  logic [3:0]                 Imem2proc_response;
  logic [63:0]                Imem2proc_data;
  logic [3:0]                 Imem2proc_tag;

  int checks = 0;
  int errors = 0;

  icache_ctrl dut (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .branch_taken          (branch_taken),
    .buff2Icache_addr      (buff2Icache_addr),
    .buff2Icache_count     (buff2Icache_count),
    .Icache2buff_addr      (Icache2buff_addr),
    .Icache2buff_data      (Icache2buff_data),
    .Icache2buff_valid     (Icache2buff_valid),
    .Icache2buff_hit_count (Icache2buff_hit_count),
    .proc2Imem_command     (proc2Imem_command),
    .proc2Imem_addr        (proc2Imem_addr),
    .Imem2proc_response    (Imem2proc_response),
    .Imem2proc_data        (Imem2proc_data),
    .Imem2proc_tag         (Imem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             en;
    logic [XLEN-1:0]  addr;
    logic [CNT_W-1:0] cnt;
    logic [N_WAY-1:0] exp_valid;
    logic [CNT_W-1:0] exp_hc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic look(input string nm, input logic [XLEN-1:0] a, input logic [CNT_W-1:0] c,
                      input logic [N_WAY-1:0] v, input logic [CNT_W-1:0] hc);
    buff2Icache_addr  = a;
    buff2Icache_count = c;
    #1;
    chk({nm, "_valid"}, 64'(Icache2buff_valid), 64'(v));
    chk({nm, "_hc"}, 64'(Icache2buff_hit_count), 64'(hc));
  endtask

  task automatic bus(input string nm, input logic [1:0] cmd, input logic [XLEN-1:0] a);
    chk({nm, "_cmd"}, 64'(proc2Imem_command), 64'(cmd));
    chk({nm, "_addr"}, 64'(proc2Imem_addr), 64'(a));
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0,   3'd3, 3'b111, 3'd3};
    vecs[1] = '{1'b1, 32'h4,   3'd3, 3'b111, 3'd3};
    vecs[2] = '{1'b1, 32'h8,   3'd2, 3'b011, 3'd2};
    vecs[3] = '{1'b1, 32'hC,   3'd3, 3'b001, 3'd1};
    vecs[4] = '{1'b1, 32'h10,  3'd3, 3'b000, 3'd0};
    vecs[5] = '{1'b1, 32'h0,   3'd0, 3'b000, 3'd0};
    vecs[6] = '{1'b0, 32'h0,   3'd3, 3'b000, 3'd0};
    vecs[7] = '{1'b1, 32'h0,   3'd1, 3'b001, 3'd1};
    vecs[8] = '{1'b1, 32'h100, 3'd2, 3'b000, 3'd0};
    vecs[9] = '{1'b1, 32'h8,   3'd3, 3'b011, 3'd2};

    reset = 1'b1; enable = 1'b1; branch_taken = 1'b0;
    buff2Icache_addr = '0; buff2Icache_count = '0;
    Imem2proc_response = '0; Imem2proc_data = '0; Imem2proc_tag = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    bus("reset", BUS_NONE, 32'h0);
    chk("reset_valid", 64'(Icache2buff_valid), 64'h0);

    // Cold miss and fill of line 0x0
    look("cold", 32'h0, 3'd3, 3'b000, 3'd0);
    tick();
    bus("cold_req", BUS_LOAD, 32'h0);
    Imem2proc_response = 4'd5;
    tick();
    Imem2proc_response = 4'd0;
    bus("cold_wait", BUS_NONE, 32'h0);
    tick();
    Imem2proc_tag  = 4'd5;
    Imem2proc_data = 64'h00000013_00100093;
    tick();
    Imem2proc_tag = 4'd0;
    look("filled", 32'h0, 3'd3, 3'b011, 3'd2);
    chk("filled_d0", 64'(Icache2buff_data[0]), 64'h00100093);
    chk("filled_d1", 64'(Icache2buff_data[1]), 64'h00000013);
    chk("filled_a2", 64'(Icache2buff_addr[2]), 64'h8);
    tick();

    // Retry: three refused cycles, accepted on the fourth with tag 7
    for (int k = 0; k < 4; k++) begin
      bus($sformatf("retry%0d", k), BUS_LOAD, 32'h8);
      Imem2proc_response = (k == 3) ? 4'd7 : 4'd0;
      tick();
    end
    Imem2proc_response = 4'd0;
    bus("retry_done", BUS_NONE, 32'h8);

    // Hit under miss, stray tag ignored
    look("hum", 32'h0, 3'd2, 3'b011, 3'd2);
    Imem2proc_tag  = 4'd3;
    Imem2proc_data = 64'hDEADBEEF_DEADBEEF;
    tick();
    Imem2proc_tag = 4'd0;
    look("stray", 32'h8, 3'd1, 3'b000, 3'd0);
    chk("stray_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    Imem2proc_tag  = 4'd7;
    Imem2proc_data = 64'h33333333_22222222;
    tick();
    Imem2proc_tag = 4'd0;
    look("two_lines", 32'h0, 3'd3, 3'b111, 3'd3);
    chk("two_lines_d2", 64'(Icache2buff_data[2]), 64'h22222222);

    // Combinational lookup table, no clock edges in between
    for (int i = 0; i < 10; i++) begin
      enable = vecs[i].en;
      look($sformatf("vec%0d", i), vecs[i].addr, vecs[i].cnt, vecs[i].exp_valid, vecs[i].exp_hc);
    end
    enable = 1'b1;

    // Conflict: 0x100 evicts line 0x0
    look("conf_miss", 32'h100, 3'd1, 3'b000, 3'd0);
    tick();
    bus("conf_req", BUS_LOAD, 32'h100);
    Imem2proc_response = 4'd2;
    tick();
    Imem2proc_response = 4'd0;
    Imem2proc_tag  = 4'd2;
    Imem2proc_data = 64'hAAAABBBB_CCCCDDDD;
    tick();
    Imem2proc_tag = 4'd0;
    look("conf_hit", 32'h100, 3'd1, 3'b001, 3'd1);
    chk("conf_d0", 64'(Icache2buff_data[0]), 64'hCCCCDDDD);
    look("evicted", 32'h0, 3'd2, 3'b000, 3'd0);
    tick();
    bus("refetch", BUS_LOAD, 32'h0);

    // Redirect during WAIT does not cancel the fill
    Imem2proc_response = 4'd4;
    tick();
    Imem2proc_response = 4'd0;
    branch_taken   = 1'b1;
    Imem2proc_tag  = 4'd4;
    Imem2proc_data = 64'h00000013_00100093;
    tick();
    Imem2proc_tag = 4'd0;
    branch_taken  = 1'b0;
    look("br_wait", 32'h0, 3'd2, 3'b011, 3'd2);

    // Redirect in IDLE delays the request by one cycle
    branch_taken = 1'b1;
    look("br_idle", 32'h10, 3'd1, 3'b000, 3'd0);
    tick();
    bus("br_idle_hold", BUS_NONE, 32'h0);
    branch_taken = 1'b0;
    tick();
    bus("br_idle_req", BUS_LOAD, 32'h10);

    // Reset during WAIT abandons the fill
    Imem2proc_response = 4'd6;
    tick();
    Imem2proc_response = 4'd0;
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    bus("rst_wait", BUS_NONE, 32'h0);
    chk("rst_wait_valid", 64'(Icache2buff_valid), 64'h0);
    Imem2proc_tag  = 4'd6;
    Imem2proc_data = 64'h12345678_9ABCDEF0;
    tick();
    Imem2proc_tag = 4'd0;
    enable = 1'b1;
    look("rst_line0", 32'h0, 3'd1, 3'b000, 3'd0);
    look("rst_line2", 32'h10, 3'd1, 3'b000, 3'd0);
    tick();
    bus("rst_refetch", BUS_LOAD, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
